fetch_ctrl: RTL and testbench

- Program-counter and fetch-sequencing stage that sits directly upstream of InstFetch.
- Drives the word address that InstFetch registers into instruction memory every clock.
- Tracks which PC belongs to the instruction returning one cycle later and presents a valid/pc/inst bundle to decode.
- Handles decode stall with a one-entry skid register, branch/jump redirect with squash, and HALT detection.

---
 rtl/fetch_ctrl.sv | 87 ++++++++
 tb/tb_fetch_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// PC / fetch sequencing ahead of InstFetch: tracks the in-flight word, a one-entry
// skid for decode stalls, redirect squash and HALT detection.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic [31:0] inst_in,
   output logic [31:0] fetch_addr,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic [31:0] if_inst,
   output logic        halted
);

   typedef enum logic {RUN, HALTED} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] infl_pc_q, infl_pc_d;
   logic        infl_valid_q, infl_valid_d;
   logic [31:0] hold_inst_q, hold_inst_d;
   logic        hold_valid_q, hold_valid_d;

   assign fetch_addr  = {2'b00, pc_q[31:2]};
   assign if_valid    = infl_valid_q;
   assign if_pc       = infl_pc_q;
   assign if_pc_plus4 = infl_pc_q + 32'd4;
   assign if_inst     = hold_valid_q ? hold_inst_q : inst_in;
   assign halted      = (state_q == HALTED);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      infl_pc_d    = infl_pc_q;
      infl_valid_d = infl_valid_q;
      hold_inst_d  = hold_inst_q;
      hold_valid_d = hold_valid_q;
      if (redirect_valid) begin
         pc_d         = redirect_pc & ~32'd3;
         infl_valid_d = 1'b0;
         hold_valid_d = 1'b0;
         state_d      = RUN;
      end else if (state_q == HALTED) begin
         // frozen; InstFetch keeps re-reading pc_q, which is harmless
      end else if (infl_valid_q && !stall && if_inst == HALT_INST) begin
         state_d      = HALTED;
         infl_valid_d = 1'b0;
         hold_valid_d = 1'b0;
      end else if (stall) begin
         // inst_in tracks the next word while pc_q is held, so park the current one
         if (!hold_valid_q && infl_valid_q) begin
            hold_inst_d  = inst_in;
            hold_valid_d = 1'b1;
         end
      end else begin
         infl_pc_d    = pc_q;
         infl_valid_d = 1'b1;
         pc_d         = pc_q + 32'd4;
         hold_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         pc_q         <= RESET_PC;
         infl_pc_q    <= 32'd0;
         infl_valid_q <= 1'b0;
         hold_inst_q  <= 32'd0;
         hold_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         infl_pc_q    <= infl_pc_d;
         infl_valid_q <= infl_valid_d;
         hold_inst_q  <= hold_inst_d;
         hold_valid_q <= hold_valid_d;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: scripted scenarios plus a randomized run against a
// delivery-stream model (decode must see mem[if_pc] for every valid cycle).
module tb_fetch_ctrl;
   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] HALT   = 32'hFFFF_FFFF;
   localparam logic [31:0] WA = 32'hA000_0001, WB = 32'hB000_0002,
                           WC = 32'hC000_0003, WD = 32'hD000_0004;

   logic        clk, rst_n, stall, redirect_valid;
   logic [31:0] redirect_pc, inst_in, fetch_addr, if_pc, if_pc_plus4, if_inst;
   logic        if_valid, halted;
   logic [31:0] lat_addr;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: offered instruction and next PC to be offered
   logic        m_valid, m_halt;
   logic [31:0] m_pc, m_next;

   fetch_ctrl #(.RESET_PC(RST_PC), .HALT_INST(HALT)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .inst_in(inst_in), .fetch_addr(fetch_addr),
      .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
      .if_inst(if_inst), .halted(halted)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] waddr);
      logic [31:0] h;
      case (waddr)
         32'h40:  h = WA;
         32'h41:  h = WB;
         32'h42:  h = WC;
         32'h43:  h = HALT;
         32'h80:  h = WD;
         default: begin
            h = (waddr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
            if (h == HALT) h = 32'h0;
         end
      endcase
      return h;
   endfunction

   // InstFetch: registers fetch_addr, returns the word one cycle later
   always @(posedge clk or negedge rst_n)
      if (!rst_n) lat_addr <= 32'h0;
      else        lat_addr <= fetch_addr;
   assign inst_in = mem_word(lat_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_valid = 1'b0; m_halt = 1'b0; m_pc = 32'h0; m_next = RST_PC;
   endtask

   task automatic cyc(input logic s, input logic r, input logic [31:0] rp);
      stall = s; redirect_valid = r; redirect_pc = rp;
      @(posedge clk); #1;
      if (r) begin
         m_valid = 1'b0; m_halt = 1'b0; m_next = rp & ~32'd3;
      end else if (m_halt) begin
      end else if (m_valid && !s && mem_word(m_pc >> 2) == HALT) begin
         m_halt = 1'b1; m_valid = 1'b0;
      end else if (!s) begin
         m_valid = 1'b1; m_pc = m_next; m_next = m_next + 32'd4;
      end
      stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      model_reset();
      #12;
      n_checks += 5;
      if (fetch_addr !== 32'h40) $display("FAIL rst_fetch_addr got %h want %h", fetch_addr, 32'h40); else n_pass++;
      if (if_valid !== 1'b0) $display("FAIL rst_if_valid got %b want 0", if_valid); else n_pass++;
      if (if_pc !== 32'h0) $display("FAIL rst_if_pc got %h want 0", if_pc); else n_pass++;
      if (if_pc_plus4 !== 32'h4) $display("FAIL rst_plus4 got %h want 4", if_pc_plus4); else n_pass++;
      if (halted !== 1'b0) $display("FAIL rst_halted got %b want 0", halted); else n_pass++;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_stream();
      logic [31:0] w [2];
      w[0] = WA; w[1] = WB;
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 1'b0, 32'h0);
         n_checks += 4;
         if (if_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %b want 1", i, if_valid); else n_pass++;
         if (if_pc !== RST_PC + 4*i) $display("FAIL stream_pc[%0d] got %h want %h", i, if_pc, RST_PC + 4*i); else n_pass++;
         if (if_inst !== w[i]) $display("FAIL stream_inst[%0d] got %h want %h", i, if_inst, w[i]); else n_pass++;
         if (fetch_addr !== 32'h41 + i) $display("FAIL stream_faddr[%0d] got %h want %h", i, fetch_addr, 32'h41 + i); else n_pass++;
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 32'h0);
         n_checks += 3;
         if (if_valid !== 1'b1) $display("FAIL stall_valid[%0d] got %b want 1", i, if_valid); else n_pass++;
         if (if_pc !== 32'h104) $display("FAIL stall_pc[%0d] got %h want 104", i, if_pc); else n_pass++;
         if (if_inst !== WB) $display("FAIL stall_inst[%0d] got %h want %h", i, if_inst, WB); else n_pass++;
      end
      cyc(1'b0, 1'b0, 32'h0);
      n_checks += 2;
      if (if_pc !== 32'h108) $display("FAIL unstall_pc got %h want 108", if_pc); else n_pass++;
      if (if_inst !== WC) $display("FAIL unstall_inst got %h want %h", if_inst, WC); else n_pass++;
   endtask

   task automatic test_redirect();
      cyc(1'b0, 1'b1, 32'h200);
      n_checks += 1;
      if (if_valid !== 1'b0) $display("FAIL redir_bubble got %b want 0", if_valid); else n_pass++;
      cyc(1'b0, 1'b0, 32'h0);
      n_checks += 3;
      if (if_valid !== 1'b1) $display("FAIL redir_valid got %b want 1", if_valid); else n_pass++;
      if (if_pc !== 32'h200) $display("FAIL redir_pc got %h want 200", if_pc); else n_pass++;
      if (if_inst !== WD) $display("FAIL redir_inst got %h want %h", if_inst, WD); else n_pass++;
      cyc(1'b0, 1'b0, 32'h0);
      n_checks += 2;
      if (if_pc !== 32'h204) $display("FAIL redir_next_pc got %h want 204", if_pc); else n_pass++;
      if (if_inst !== mem_word(32'h81)) $display("FAIL redir_next_inst got %h want %h", if_inst, mem_word(32'h81)); else n_pass++;
      cyc(1'b0, 1'b1, 32'h203);
      cyc(1'b0, 1'b0, 32'h0);
      n_checks += 2;
      if (if_pc !== 32'h200) $display("FAIL redir_mask_pc got %h want 200", if_pc); else n_pass++;
      if (if_inst !== WD) $display("FAIL redir_mask_inst got %h want %h", if_inst, WD); else n_pass++;
   endtask

   task automatic test_stall_redirect();
      cyc(1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 32'h0);
      cyc(1'b1, 1'b1, 32'h100);
      n_checks += 1;
      if (if_valid !== 1'b0) $display("FAIL stredir_bubble got %b want 0", if_valid); else n_pass++;
      cyc(1'b0, 1'b0, 32'h0);
      n_checks += 3;
      if (if_valid !== 1'b1) $display("FAIL stredir_valid got %b want 1", if_valid); else n_pass++;
      if (if_pc !== 32'h100) $display("FAIL stredir_pc got %h want 100", if_pc); else n_pass++;
      if (if_inst !== WA) $display("FAIL stredir_inst got %h want %h", if_inst, WA); else n_pass++;
   endtask

   task automatic test_halt();
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         n_checks += 4;
         if (if_valid !== 1'b1) $display("FAIL halt_deliver_valid[%0d] got %b want 1", i, if_valid); else n_pass++;
         if (if_pc !== 32'h10C) $display("FAIL halt_deliver_pc[%0d] got %h want 10c", i, if_pc); else n_pass++;
         if (if_inst !== HALT) $display("FAIL halt_deliver_inst[%0d] got %h want %h", i, if_inst, HALT); else n_pass++;
         if (halted !== 1'b0) $display("FAIL halt_early[%0d] got %b want 0", i, halted); else n_pass++;
         cyc(i < 2, 1'b0, 32'h0);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks += 3;
         if (halted !== 1'b1) $display("FAIL halted[%0d] got %b want 1", i, halted); else n_pass++;
         if (if_valid !== 1'b0) $display("FAIL halted_valid[%0d] got %b want 0", i, if_valid); else n_pass++;
         if (fetch_addr !== 32'h44) $display("FAIL halted_faddr[%0d] got %h want 44", i, fetch_addr); else n_pass++;
         cyc(1'b0, 1'b0, 32'h0);
      end
      cyc(1'b0, 1'b1, 32'h0);
      n_checks += 2;
      if (halted !== 1'b0) $display("FAIL unhalt got %b want 0", halted); else n_pass++;
      if (if_valid !== 1'b0) $display("FAIL unhalt_bubble got %b want 0", if_valid); else n_pass++;
      cyc(1'b0, 1'b0, 32'h0);
      n_checks += 2;
      if (if_pc !== 32'h0 || if_valid !== 1'b1) $display("FAIL resume_pc got %h/%b want 0/1", if_pc, if_valid); else n_pass++;
      if (if_inst !== mem_word(32'h0)) $display("FAIL resume_inst got %h want %h", if_inst, mem_word(32'h0)); else n_pass++;
   endtask

   task automatic test_async_reset();
      cyc(1'b1, 1'b0, 32'h0);
      stall = 1'b1;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_checks += 4;
      if (if_valid !== 1'b0) $display("FAIL arst_valid got %b want 0", if_valid); else n_pass++;
      if (if_pc !== 32'h0) $display("FAIL arst_pc got %h want 0", if_pc); else n_pass++;
      if (if_pc_plus4 !== 32'h4) $display("FAIL arst_plus4 got %h want 4", if_pc_plus4); else n_pass++;
      if (fetch_addr !== 32'h40) $display("FAIL arst_faddr got %h want 40", fetch_addr); else n_pass++;
      #2 rst_n = 1'b1; stall = 1'b0;
      cyc(1'b0, 1'b0, 32'h0);
      n_checks += 2;
      if (if_pc !== 32'h100 || if_valid !== 1'b1) $display("FAIL arst_restart_pc got %h/%b want 100/1", if_pc, if_valid); else n_pass++;
      if (if_inst !== WA) $display("FAIL arst_restart_inst got %h want %h", if_inst, WA); else n_pass++;
   endtask

   task automatic test_wrap();
      cyc(1'b0, 1'b1, 32'hFFFF_FFFC);
      n_checks += 1;
      if (fetch_addr !== 32'h3FFF_FFFF) $display("FAIL wrap_faddr0 got %h want 3fffffff", fetch_addr); else n_pass++;
      cyc(1'b0, 1'b0, 32'h0);
      n_checks += 3;
      if (if_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc got %h want fffffffc", if_pc); else n_pass++;
      if (if_pc_plus4 !== 32'h0) $display("FAIL wrap_plus4 got %h want 0", if_pc_plus4); else n_pass++;
      if (fetch_addr !== 32'h0) $display("FAIL wrap_faddr got %h want 0", fetch_addr); else n_pass++;
      cyc(1'b0, 1'b0, 32'h0);
      n_checks += 1;
      if (if_pc !== 32'h0) $display("FAIL wrap_next_pc got %h want 0", if_pc); else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         logic        s, r;
         logic [31:0] rp;
         s  = ($urandom_range(0, 2) == 0);
         r  = ($urandom_range(0, 15) == 0);
         rp = ($urandom_range(0, 2) == 0) ? $urandom : (32'h100 + $urandom_range(0, 15));
         cyc(s, r, rp);
         n_checks += 3;
         if (if_valid !== m_valid) $display("FAIL rnd_valid[%0d] got %b want %b", i, if_valid, m_valid); else n_pass++;
         if (halted !== m_halt) $display("FAIL rnd_halted[%0d] got %b want %b", i, halted, m_halt); else n_pass++;
         if (fetch_addr !== (m_next >> 2)) $display("FAIL rnd_faddr[%0d] got %h want %h", i, fetch_addr, m_next >> 2); else n_pass++;
         if (m_valid) begin
            n_checks += 3;
            if (if_pc !== m_pc) $display("FAIL rnd_pc[%0d] got %h want %h", i, if_pc, m_pc); else n_pass++;
            if (if_pc_plus4 !== m_pc + 32'd4) $display("FAIL rnd_plus4[%0d] got %h want %h", i, if_pc_plus4, m_pc + 32'd4); else n_pass++;
            if (if_inst !== mem_word(m_pc >> 2)) $display("FAIL rnd_inst[%0d] got %h want %h", i, if_inst, mem_word(m_pc >> 2)); else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_stall_redirect();
      test_halt();
      test_async_reset();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
